sram_wb_arbiter: RTL and testbench

Two-master Wishbone arbiter that shares the single-port-per-direction SRAM Wishbone slave between the management/CPU bus (master 0) and the on-chip accelerator bus (master 1). It sits directly upstream of the SRAM Wishbone wrapper. It grants one master at a time with round-robin fairness and holds the grant for the whole transaction. A watchdog releases the bus if the slave never acknowledges.

---
 rtl/sram_wb_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_sram_wb_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_wb_arbiter
// Purpose  : Two-master round-robin Wishbone arbiter in front of the SRAM
//            Wishbone slave. Master 0 is the management/CPU bus and master 1
//            is the accelerator bus. The grant is held for a whole
//            transaction. A watchdog releases a slave that never acknowledges.
// Revision : 1.0  initial release
// ============================================================================
module sram_wb_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  // master 0
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,
  // master 1
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,
  // shared slave
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  // current grant, one-hot, bit0 = master 0
  output logic [1:0]  grant_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_GRANT0 = 2'd1;
  localparam logic [1:0] c_GRANT1 = 2'd2;

  // Counter is wide enough to hold TIMEOUT_CYCLES itself, so it never wraps
  // before the terminal value is seen.
  localparam int              c_CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CW-1:0] c_TERM = c_CW'(TIMEOUT_CYCLES - 1);
  localparam logic [c_CW-1:0] c_MAX  = {c_CW{1'b1}};

  // --------------------------------------------------------------------------
  // Registers and wires
  // --------------------------------------------------------------------------
  logic [1:0]      r_state;
  logic            r_last;       // 1'b0: m0 served last, 1'b1: m1 served last
  logic [c_CW-1:0] r_cnt;

  logic [1:0]      w_state_nxt;
  logic            w_last_nxt;
  logic [c_CW-1:0] w_cnt_nxt;

  logic            w_req0;
  logic            w_req1;
  logic            w_gnt_cyc;    // cyc of whichever master currently holds the bus
  logic            w_cnt_hit;
  logic            w_tmo;        // watchdog fires this cycle (ack absent, master still in cycle)
  logic            w_exit;       // current grant ends at the next edge

  assign w_req0 = m0_cyc_i & m0_stb_i;
  assign w_req1 = m1_cyc_i & m1_stb_i;

  // Select the cycle line of the granted master for the exit/timeout decisions.
  always_comb begin
    w_gnt_cyc = 1'b0;
    case (r_state)
      c_GRANT0: w_gnt_cyc = m0_cyc_i;
      c_GRANT1: w_gnt_cyc = m1_cyc_i;
      default:  w_gnt_cyc = 1'b0;
    endcase
  end

  // Ack has priority over the watchdog; an aborting master gets no error either.
  assign w_cnt_hit = (r_cnt == c_TERM);
  assign w_tmo     = w_gnt_cyc & ~s_ack_i & w_cnt_hit;
  assign w_exit    = s_ack_i | ~w_gnt_cyc | w_cnt_hit;

  // --------------------------------------------------------------------------
  // State register: FSM state, round-robin pointer and watchdog counter.
  // Reset leaves last_served pointing at m1 so m0 wins the first tie.
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= c_IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic: round-robin arbitration in IDLE, release in GRANTx.
  // Every grant returns through IDLE so s_stb_o drops between transactions.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_cnt_nxt   = '0;
    case (r_state)
      c_IDLE: begin
        if (w_req0 && (!w_req1 || r_last)) begin
          w_state_nxt = c_GRANT0;
        end else if (w_req1) begin
          w_state_nxt = c_GRANT1;
        end
      end
      c_GRANT0: begin
        if (w_exit) begin
          w_state_nxt = c_IDLE;
          w_last_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = (r_cnt == c_MAX) ? r_cnt : r_cnt + 1'b1;
        end
      end
      c_GRANT1: begin
        if (w_exit) begin
          w_state_nxt = c_IDLE;
          w_last_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = (r_cnt == c_MAX) ? r_cnt : r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = c_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: steer the granted master onto the slave and route the
  // response back; everything is zero in IDLE and toward the idle master.
  // --------------------------------------------------------------------------
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = 4'h0;
    s_adr_o  = 32'h0;
    s_dat_o  = 32'h0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = 32'h0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = 32'h0;
    grant_o  = 2'b00;
    case (r_state)
      c_GRANT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = w_tmo;
        m0_dat_o = s_dat_i;
        grant_o  = 2'b01;
      end
      c_GRANT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = w_tmo;
        m1_dat_o = s_dat_i;
        grant_o  = 2'b10;
      end
      default: begin
        grant_o = 2'b00;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_wb_arbiter
// Purpose  : Directed self-checking bench for sram_wb_arbiter with a
//            one-cycle-latency slave model whose ack can be disabled.
// Revision : 1.0  initial release
// ============================================================================
module tb_sram_wb_arbiter;

  localparam int TIMEOUT_CYCLES = 16;

  logic        clk;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we;
  logic [3:0]  m0_sel;
  logic [31:0] m0_adr, m0_wdat;
  logic        m0_ack, m0_err;
  logic [31:0] m0_rdat;
  logic        m1_cyc, m1_stb, m1_we;
  logic [3:0]  m1_sel;
  logic [31:0] m1_adr, m1_wdat;
  logic        m1_ack, m1_err;
  logic [31:0] m1_rdat;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat;
  logic        r_s_ack;
  logic [31:0] r_s_rdat;
  logic [1:0]  grant;
  logic        ack_en;

  int n_total = 0;
  int n_bad   = 0;

  sram_wb_arbiter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .m0_cyc_i (m0_cyc),
    .m0_stb_i (m0_stb),
    .m0_we_i  (m0_we),
    .m0_sel_i (m0_sel),
    .m0_adr_i (m0_adr),
    .m0_dat_i (m0_wdat),
    .m0_ack_o (m0_ack),
    .m0_err_o (m0_err),
    .m0_dat_o (m0_rdat),
    .m1_cyc_i (m1_cyc),
    .m1_stb_i (m1_stb),
    .m1_we_i  (m1_we),
    .m1_sel_i (m1_sel),
    .m1_adr_i (m1_adr),
    .m1_dat_i (m1_wdat),
    .m1_ack_o (m1_ack),
    .m1_err_o (m1_err),
    .m1_dat_o (m1_rdat),
    .s_cyc_o  (s_cyc),
    .s_stb_o  (s_stb),
    .s_we_o   (s_we),
    .s_sel_o  (s_sel),
    .s_adr_o  (s_adr),
    .s_dat_o  (s_wdat),
    .s_ack_i  (r_s_ack),
    .s_dat_i  (r_s_rdat),
    .grant_o  (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: acks the cycle after stb; read data = address ^ 0xA5A50000.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_ack  <= 1'b0;
      r_s_rdat <= 32'h0;
    end else begin
      r_s_ack  <= ack_en & s_cyc & s_stb & ~r_s_ack;
      r_s_rdat <= s_adr ^ 32'hA5A5_0000;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m0(input logic req, input logic we, input logic [31:0] adr, input logic [31:0] dat);
    m0_cyc = req; m0_stb = req; m0_we = we; m0_sel = 4'hF; m0_adr = adr; m0_wdat = dat;
  endtask

  task automatic drive_m1(input logic req, input logic we, input logic [31:0] adr, input logic [31:0] dat);
    m1_cyc = req; m1_stb = req; m1_we = we; m1_sel = 4'hF; m1_adr = adr; m1_wdat = dat;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  logic [1:0] exp_seq [12];
  int n_err, n_ack, err_at;
  logic stb_last, gnt_last;

  initial begin
    ack_en = 1'b1;
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
    drive_m1(1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    #2;
    chk("reset_grant", {30'h0, grant}, 32'h0);
    chk("reset_stb", {31'h0, s_stb}, 32'h0);
    do_reset();
    step();
    chk("idle_grant", {30'h0, grant}, 32'h0);

    // Single m0 read at 0x10
    drive_m0(1'b1, 1'b0, 32'h10, 32'h0);
    step();
    chk("t1_grant", {30'h0, grant}, 32'h1);
    chk("t1_stb", {31'h0, s_stb}, 32'h1);
    chk("t1_adr", s_adr, 32'h10);
    chk("t1_m1_quiet", {m1_ack, m1_err, 30'h0} | m1_rdat, 32'h0);
    step();
    chk("t1_ack", {31'h0, m0_ack}, 32'h1);
    chk("t1_dat", m0_rdat, 32'hA5A5_0010);
    chk("t1_m1_quiet2", {m1_ack, m1_err, 30'h0} | m1_rdat, 32'h0);
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("t1_idle", {30'h0, grant}, 32'h0);
    chk("t1_idle_stb", {31'h0, s_stb}, 32'h0);

    // Both masters request continuously after reset: m0, m1, m0, m1
    do_reset();
    exp_seq = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00,
                2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
    drive_m0(1'b1, 1'b0, 32'h20, 32'h0);
    drive_m1(1'b1, 1'b0, 32'h24, 32'h0);
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("t2_grant%0d", i), {30'h0, grant}, {30'h0, exp_seq[i]});
    end
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
    drive_m1(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // m1 requesting continuously while m0 writes 0xDEADBEEF to 0x40
    do_reset();
    drive_m1(1'b1, 1'b0, 32'h80, 32'h0);
    step();
    chk("t3_g1", {30'h0, grant}, 32'h2);
    drive_m0(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
    step();
    chk("t3_m1ack", {31'h0, m1_ack}, 32'h1);
    chk("t3_m1dat", m1_rdat, 32'hA5A5_0080);
    step();
    chk("t3_idle", {30'h0, grant}, 32'h0);
    step();
    chk("t3_g0", {30'h0, grant}, 32'h1);
    chk("t3_wdat", s_wdat, 32'hDEAD_BEEF);
    chk("t3_we", {31'h0, s_we}, 32'h1);
    chk("t3_sel", {28'h0, s_sel}, 32'hF);
    chk("t3_adr", s_adr, 32'h40);
    step();
    chk("t3_m0ack", {31'h0, m0_ack}, 32'h1);
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();
    chk("t3_g1_again", {30'h0, grant}, 32'h2);
    drive_m1(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Watchdog: slave never acks, m1 read
    ack_en = 1'b0;
    drive_m1(1'b1, 1'b0, 32'hC0, 32'h0);
    n_err = 0; n_ack = 0; err_at = 0; stb_last = 1'b0; gnt_last = 1'b0;
    for (int i = 1; i <= TIMEOUT_CYCLES; i++) begin
      step();
      if (m1_err) begin n_err++; err_at = i; end
      if (m1_ack) n_ack++;
      if (i == TIMEOUT_CYCLES) begin stb_last = s_stb; gnt_last = grant[1]; end
    end
    chk("t4_err_count", n_err, 32'd1);
    chk("t4_err_cycle", err_at, 32'd16);
    chk("t4_ack_count", n_ack, 32'd0);
    chk("t4_stb_in_err", {31'h0, stb_last}, 32'h1);
    chk("t4_gnt_in_err", {31'h0, gnt_last}, 32'h1);
    drive_m1(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("t4_idle", {30'h0, grant}, 32'h0);
    chk("t4_err_clear", {31'h0, m1_err}, 32'h0);
    ack_en = 1'b1;

    // m0 aborts in its first grant cycle while m1 is pending
    do_reset();
    drive_m0(1'b1, 1'b0, 32'h44, 32'h0);
    drive_m1(1'b1, 1'b0, 32'h48, 32'h0);
    step();
    chk("t5_g0", {30'h0, grant}, 32'h1);
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("t5_noack", {30'h0, m0_ack, m0_err}, 32'h0);
    step();
    chk("t5_idle", {30'h0, grant}, 32'h0);
    chk("t5_noack2", {30'h0, m0_ack, m0_err}, 32'h0);
    step();
    chk("t5_g1", {30'h0, grant}, 32'h2);
    step();
    chk("t5_m1ack", {31'h0, m1_ack}, 32'h1);
    drive_m1(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Reset mid-grant: m0 served first so a plain tie would go to m1
    drive_m0(1'b1, 1'b0, 32'h50, 32'h0);
    step();
    step();
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    drive_m0(1'b1, 1'b0, 32'h54, 32'h0);
    drive_m1(1'b1, 1'b0, 32'h58, 32'h0);
    step();
    chk("t6_g1_before", {30'h0, grant}, 32'h2);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_grant", {30'h0, grant}, 32'h0);
    chk("t6_rst_sbus", {29'h0, s_cyc, s_stb, s_we} | s_adr, 32'h0);
    chk("t6_rst_resp", {30'h0, m1_ack, m1_err} | m1_rdat, 32'h0);
    #2;
    rst_n = 1'b1;
    step();
    chk("t6_tie_m0", {30'h0, grant}, 32'h1);
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
    drive_m1(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
